// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, stall hold buffer, redirect squashing.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] pc,
    output logic [31:0] pcAdd4,
    output logic [31:0] inst,
    output logic        instValid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] stallCycles
`endif
);

    typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

    state_e      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_discard;
    logic [31:0] r_hold_inst;
    logic [31:0] r_pc;
    logic [31:0] r_pc_add4;
    logic [31:0] r_inst;
    logic        r_inst_valid;

    logic        w_deliver;
    logic [31:0] w_deliver_inst;
    logic [31:0] w_req_pc_add4;

    assign w_req_pc_add4 = r_req_pc + 32'd4;

    // A delivery happens from WAIT (fresh response) or HOLD (buffered response), never on redirect.
    assign w_deliver = !redirect && !stall &&
                       ((r_state == StWait && imemRvalid && !r_discard) || (r_state == StHold));
    assign w_deliver_inst = (r_state == StHold) ? r_hold_inst : imemRdata;

    assign imemReq   = (r_state == StFetch);
    assign imemAddr  = r_fetch_pc & 32'hFFFF_FFFC;
    assign pc        = r_pc;
    assign pcAdd4    = r_pc_add4;
    assign inst      = r_inst;
    assign instValid = r_inst_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StFetch;
            r_fetch_pc   <= RESET_PC;
            r_req_pc     <= 32'd0;
            r_discard    <= 1'b0;
            r_hold_inst  <= 32'd0;
            r_pc         <= 32'd0;
            r_pc_add4    <= 32'd0;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
        end else begin
            // Bubble unless a delivery overrides it below.
            r_pc         <= 32'd0;
            r_pc_add4    <= 32'd0;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            if (w_deliver) begin
                r_pc         <= r_req_pc;
                r_pc_add4    <= w_req_pc_add4;
                r_inst       <= w_deliver_inst;
                r_inst_valid <= 1'b1;
                r_fetch_pc   <= w_req_pc_add4;
                r_state      <= StFetch;
            end else if (redirect) begin
                r_fetch_pc <= redirectPc & 32'hFFFF_FFFC;
                unique case (r_state)
                    StFetch: begin
                        // A grant in the redirect cycle is still outstanding and must be squashed.
                        if (imemGnt) begin
                            r_req_pc  <= r_fetch_pc;
                            r_discard <= 1'b1;
                            r_state   <= StWait;
                        end
                    end
                    StWait: begin
                        if (imemRvalid) begin
                            r_discard <= 1'b0;
                            r_state   <= StFetch;
                        end else begin
                            r_discard <= 1'b1;
                        end
                    end
                    StHold:  r_state <= StFetch;
                    default: r_state <= StFetch;
                endcase
            end else begin
                unique case (r_state)
                    StFetch: begin
                        if (imemGnt) begin
                            r_req_pc <= r_fetch_pc;
                            r_state  <= StWait;
                        end
                    end
                    StWait: begin
                        if (imemRvalid) begin
                            if (r_discard) begin
                                r_discard <= 1'b0;
                                r_state   <= StFetch;
                            end else if (stall) begin
                                r_hold_inst <= imemRdata;
                                r_state     <= StHold;
                            end
                        end
                    end
                    StHold:  r_state <= StHold;
                    default: r_state <= StFetch;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_cycles;

    assign fetchCount  = r_fetch_count;
    assign stallCycles = r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count  <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (w_deliver) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (r_state == StHold) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/hold, redirects, reset abandon, PC wrap.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    logic        a_req;
    logic [31:0] a_addr;
    logic [31:0] a_pc;
    logic [31:0] a_pc4;
    logic [31:0] a_inst;
    logic        a_valid;
    logic        b_req;
    logic [31:0] b_addr;
    logic [31:0] b_pc;
    logic [31:0] b_pc4;
    logic [31:0] b_inst;
    logic        b_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] a_fcnt;
    logic [31:0] a_scnt;
    logic [31:0] b_fcnt;
    logic [31:0] b_scnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit u_dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .imemReq    (a_req),
        .imemAddr   (a_addr),
        .imemGnt    (gnt),
        .imemRvalid (rvalid),
        .imemRdata  (rdata),
        .pc         (a_pc),
        .pcAdd4     (a_pc4),
        .inst       (a_inst),
        .instValid  (a_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount (a_fcnt),
        .stallCycles(a_scnt)
`endif
    );

    fetch_unit #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .imemReq    (b_req),
        .imemAddr   (b_addr),
        .imemGnt    (gnt),
        .imemRvalid (rvalid),
        .imemRdata  (rdata),
        .pc         (b_pc),
        .pcAdd4     (b_pc4),
        .inst       (b_inst),
        .instValid  (b_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount (b_fcnt),
        .stallCycles(b_scnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'd0;
        gnt = 1'b1; rvalid = 1'b0; rdata = 32'd0;
        #1;
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_pc", a_pc, 32'd0);
        chk("rst_inst", a_inst, 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_addr_wrap", b_addr, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fcnt", a_fcnt, 32'd0);
        chk("rst_scnt", a_scnt, 32'd0);
`endif
        tick();
        reset = 1'b0;
        chk("rel_req", {31'd0, a_req}, 32'd1);

        // Back-to-back streaming: grant, then response the next cycle.
        tick();
        chk("wait_req", {31'd0, a_req}, 32'd0);
        rvalid = 1'b1; rdata = 32'h0050_0093;
        tick();
        chk("d0_valid", {31'd0, a_valid}, 32'd1);
        chk("d0_pc", a_pc, 32'd0);
        chk("d0_pc4", a_pc4, 32'd4);
        chk("d0_inst", a_inst, 32'h0050_0093);
        chk("d0_addr", a_addr, 32'd4);
        chk("wrap_pc", b_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", b_pc4, 32'd0);
        chk("wrap_addr", b_addr, 32'd0);
        rvalid = 1'b0;
        tick();
        chk("bub_valid", {31'd0, a_valid}, 32'd0);
        chk("bub_pc", a_pc, 32'd0);
        rvalid = 1'b1; rdata = 32'h0010_0113;
        tick();
        chk("d1_pc", a_pc, 32'd4);
        chk("d1_inst", a_inst, 32'h0010_0113);
        rvalid = 1'b0;

        // Stall for three cycles on the response for pc=8.
        tick();
        rvalid = 1'b1; rdata = 32'h0020_0193; stall = 1'b1;
        tick();
        chk("hold1_valid", {31'd0, a_valid}, 32'd0);
        chk("hold1_req", {31'd0, a_req}, 32'd0);
        rvalid = 1'b0;
        tick();
        chk("hold2_valid", {31'd0, a_valid}, 32'd0);
        chk("hold2_req", {31'd0, a_req}, 32'd0);
        tick();
        chk("hold3_valid", {31'd0, a_valid}, 32'd0);
        chk("hold3_req", {31'd0, a_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk("d2_valid", {31'd0, a_valid}, 32'd1);
        chk("d2_pc", a_pc, 32'd8);
        chk("d2_inst", a_inst, 32'h0020_0193);
        chk("d2_addr", a_addr, 32'h0000_000C);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_f3", a_fcnt, 32'd3);
        chk("cnt_s3", a_scnt, 32'd3);
`endif

        // Redirect while waiting: the in-flight response must be dropped.
        tick();
        redirect = 1'b1; redirectPc = 32'h0000_0103;
        tick();
        chk("rdw_req", {31'd0, a_req}, 32'd0);
        redirect = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_0001;
        tick();
        chk("rdw_drop", {31'd0, a_valid}, 32'd0);
        chk("rdw_addr", a_addr, 32'h0000_0100);
        chk("rdw_reqhi", {31'd0, a_req}, 32'd1);
        rvalid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h0030_0213;
        tick();
        chk("d3_pc", a_pc, 32'h0000_0100);
        chk("d3_pc4", a_pc4, 32'h0000_0104);
        chk("d3_inst", a_inst, 32'h0030_0213);
        rvalid = 1'b0;

        // Redirect coincident with the response.
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_0002; redirect = 1'b1; redirectPc = 32'h0000_0200;
        tick();
        chk("rdv_drop", {31'd0, a_valid}, 32'd0);
        chk("rdv_addr", a_addr, 32'h0000_0200);
        chk("rdv_req", {31'd0, a_req}, 32'd1);
        redirect = 1'b0; rvalid = 1'b0;

        // Redirect while holding a stalled instruction.
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_0003; stall = 1'b1;
        tick();
        chk("rdh_bub", {31'd0, a_valid}, 32'd0);
        rvalid = 1'b0; redirect = 1'b1; redirectPc = 32'h0000_0300;
        tick();
        chk("rdh_drop", {31'd0, a_valid}, 32'd0);
        chk("rdh_addr", a_addr, 32'h0000_0300);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk("rdh_nodeliv", {31'd0, a_valid}, 32'd0);
        rvalid = 1'b1; rdata = 32'h0040_0293;
        tick();
        chk("d4_pc", a_pc, 32'h0000_0300);
        chk("d4_inst", a_inst, 32'h0040_0293);
        rvalid = 1'b0;

        // Redirect in the same cycle as a grant: that grant's response is squashed.
        redirect = 1'b1; redirectPc = 32'h0000_0400;
        tick();
        chk("rdg_req", {31'd0, a_req}, 32'd0);
        redirect = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_0004;
        tick();
        chk("rdg_drop", {31'd0, a_valid}, 32'd0);
        chk("rdg_addr", a_addr, 32'h0000_0400);
        rvalid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_f5", a_fcnt, 32'd5);
        chk("cnt_s4", a_scnt, 32'd4);
`endif

        // Asynchronous reset in WAIT; a stray response afterwards must be ignored.
        tick();
        reset = 1'b1; gnt = 1'b0;
        #1;
        chk("arst_req", {31'd0, a_req}, 32'd1);
        chk("arst_addr", a_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_fcnt", a_fcnt, 32'd0);
        chk("arst_scnt", a_scnt, 32'd0);
`endif
        tick();
        reset = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_0005;
        tick();
        chk("stray_valid", {31'd0, a_valid}, 32'd0);
        chk("stray_req", {31'd0, a_req}, 32'd1);
        chk("stray_addr", a_addr, 32'd0);
        rvalid = 1'b0; gnt = 1'b1;
        tick();
        rvalid = 1'b1; rdata = 32'h0060_0313;
        tick();
        chk("d5_valid", {31'd0, a_valid}, 32'd1);
        chk("d5_pc", a_pc, 32'd0);
        chk("d5_inst", a_inst, 32'h0060_0313);
        rvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
